// File: rtl/net_sim_pkg.sv
// Shared types and constants for the Boolean-network update engine.
package net_sim_pkg;

    typedef enum logic [1:0] {
        MODE_SYNC = 2'd0,
        MODE_RR   = 2'd1,
        MODE_RAND = 2'd2,
        MODE_RSVD = 2'd3
    } update_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step Galois LFSR advance (right shift, feedback from bit 0).
module lfsr_step
    import net_sim_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(LFSR_TAPS_16)
) (
    input  logic [LFSR_W-1:0] i_lfsr,
    output logic [LFSR_W-1:0] o_lfsr
);

    assign o_lfsr = i_lfsr[0] ? ((i_lfsr >> 1) ^ TAPS) : (i_lfsr >> 1);

endmodule

// File: rtl/network_update_engine.sv
// Boolean-network simulation engine: owns state, iteration count and run control;
// rules are evaluated by an external combinational block via rule_state/rule_next.
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | updating nodes according to the latched mode
// S_DONE | run finished (limit or fixed point), waiting for start
module network_update_engine
    import net_sim_pkg::*;
#(
    parameter int N_NODES = 61,
    parameter int ITER_W  = 10,
    parameter int LFSR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [N_NODES-1:0] init_state,
    input  logic [ITER_W-1:0]  max_iter,
    input  logic [N_NODES-1:0] toggle_mask,
    input  logic [N_NODES-1:0] toggle_value,
    input  logic [ITER_W-1:0]  toggle_iter,
    input  logic [LFSR_W-1:0]  seed,
    output logic [N_NODES-1:0] rule_state,
    input  logic [N_NODES-1:0] rule_next,
    output logic [N_NODES-1:0] state,
    output logic [ITER_W-1:0]  iteration,
    output logic               state_valid,
    output logic               busy,
    output logic               done,
    output logic               steady
);

    localparam int               IDX_W    = $clog2(N_NODES);
    localparam logic [IDX_W:0]   NODES_X  = (IDX_W+1)'(N_NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = '1;

    fsm_e               r_fsm;
    fsm_e               w_fsm_nxt;
    update_mode_e       r_mode;
    logic [N_NODES-1:0] r_state;
    logic [N_NODES-1:0] r_mask;
    logic [N_NODES-1:0] r_tval;
    logic [ITER_W-1:0]  r_iter;
    logic [ITER_W-1:0]  r_max_iter;
    logic [ITER_W-1:0]  r_titer;
    logic [IDX_W-1:0]   r_idx;
    logic [LFSR_W-1:0]  r_lfsr;
    logic               r_changed;
    logic               r_fp;
    logic               r_valid;
    logic               r_steady;

    logic [LFSR_W-1:0]  w_lfsr_nxt;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [N_NODES-1:0] w_onehot;
    logic [N_NODES-1:0] w_forced;
    logic [N_NODES-1:0] w_merged;
    logic [N_NODES-1:0] w_new;
    logic [ITER_W-1:0]  w_iter_inc;
    logic               w_sync;
    logic               w_stall;
    logic               w_chg;
    logic               w_bound;
    logic               w_fp;
    logic               w_stop;
    logic               w_load;

    lfsr_step #(.LFSR_W(LFSR_W)) u_lfsr_step (
        .i_lfsr (r_lfsr),
        .o_lfsr (w_lfsr_nxt)
    );

    always_comb begin
        w_sync    = (r_mode == MODE_SYNC) || (r_mode == MODE_RSVD);
        w_cand    = r_lfsr[IDX_W-1:0];
        w_stall   = (r_mode == MODE_RAND) && ({1'b0, w_cand} >= NODES_X);
        w_upd_idx = (r_mode == MODE_RAND) ? w_cand : r_idx;
        w_onehot  = {{(N_NODES-1){1'b0}}, 1'b1} << w_upd_idx;
        w_forced  = (r_iter < r_titer) ? r_tval : '0;
        w_merged  = w_sync ? rule_next : ((r_state & ~w_onehot) | (rule_next & w_onehot));
        // Forcing covers every masked bit each cycle, not just the node being updated
        w_new     = (w_merged & ~r_mask) | (w_forced & r_mask);
        w_chg     = (w_new != r_state);
        w_bound   = w_sync || (!w_stall && (r_idx == LAST_IDX));
        w_fp      = w_bound && !(r_changed || w_chg) && (r_iter >= r_titer);
        w_stop    = r_fp || (r_iter == r_max_iter);
        w_iter_inc = (r_iter == ITER_MAX) ? r_iter : r_iter + 1'b1;
        w_load    = start && (r_fsm != S_RUN);
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (start)  w_fsm_nxt = S_RUN;
            S_RUN:   if (w_stop) w_fsm_nxt = S_DONE;
            S_DONE:  if (start)  w_fsm_nxt = S_RUN;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_SYNC;
            r_state    <= '0;
            r_mask     <= '0;
            r_tval     <= '0;
            r_iter     <= '0;
            r_max_iter <= '0;
            r_titer    <= '0;
            r_idx      <= '0;
            r_lfsr     <= LFSR_W'(1);
            r_changed  <= 1'b0;
            r_fp       <= 1'b0;
            r_valid    <= 1'b0;
            r_steady   <= 1'b0;
        end else if (w_load) begin
            r_mode     <= update_mode_e'(mode);
            r_state    <= init_state;
            r_mask     <= toggle_mask;
            r_tval     <= toggle_value;
            r_iter     <= '0;
            r_max_iter <= max_iter;
            r_titer    <= toggle_iter;
            r_idx      <= '0;
            r_lfsr     <= (seed == '0) ? LFSR_W'(1) : seed;
            r_changed  <= 1'b0;
            r_fp       <= 1'b0;
            r_valid    <= 1'b0;
            r_steady   <= 1'b0;
        end else if (r_fsm == S_RUN) begin
            r_valid <= 1'b0;
            r_lfsr  <= w_lfsr_nxt;
            // Termination is taken one cycle after the final boundary so done trails state_valid
            if (w_stop) begin
                r_steady <= r_fp;
            end else if (!w_stall) begin
                r_state <= w_new;
                if (w_bound) begin
                    r_iter    <= w_iter_inc;
                    r_valid   <= 1'b1;
                    r_idx     <= '0;
                    r_changed <= 1'b0;
                    r_fp      <= w_fp;
                end else begin
                    r_idx     <= r_idx + 1'b1;
                    r_changed <= r_changed || w_chg;
                end
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign rule_state  = r_state;
    assign state       = r_state;
    assign iteration   = r_iter;
    assign state_valid = r_valid;
    assign busy        = (r_fsm == S_RUN);
    assign done        = (r_fsm == S_DONE);
    assign steady      = r_steady;

endmodule

// File: tb/tb_network_update_engine.sv
// Directed bench: a 4-node instance for sync/round-robin/toggle/handshake runs and
// a 5-node instance for random-order runs, with bench-side rule blocks.
module tb_network_update_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 4-node instance
    logic        start4;
    logic [1:0]  mode4;
    logic [3:0]  init4, mask4, tval4, rs4, rn4, st4;
    logic [9:0]  max4, titer4, it4;
    logic [15:0] seed4;
    logic        sv4, busy4, done4, steady4;
    int          rule_sel;

    // 5-node instance, rule is always bitwise invert
    logic        start5;
    logic [1:0]  mode5;
    logic [4:0]  init5, mask5, tval5, rs5, rn5, st5;
    logic [9:0]  max5, titer5, it5;
    logic [15:0] seed5;
    logic        sv5, busy5, done5, steady5;

    always_comb begin
        rn4 = rs4;
        case (rule_sel)
            0:       rn4 = {rs4[2:0], rs4[3]};
            1:       rn4 = rs4;
            default: rn4 = ~rs4;
        endcase
        rn5 = ~rs5;
    end

    network_update_engine #(.N_NODES(4), .ITER_W(10), .LFSR_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4),
        .init_state(init4), .max_iter(max4), .toggle_mask(mask4),
        .toggle_value(tval4), .toggle_iter(titer4), .seed(seed4),
        .rule_state(rs4), .rule_next(rn4), .state(st4), .iteration(it4),
        .state_valid(sv4), .busy(busy4), .done(done4), .steady(steady4)
    );

    network_update_engine #(.N_NODES(5), .ITER_W(10), .LFSR_W(16)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode5),
        .init_state(init5), .max_iter(max5), .toggle_mask(mask5),
        .toggle_value(tval5), .toggle_iter(titer5), .seed(seed5),
        .rule_state(rs5), .rule_next(rn5), .state(st5), .iteration(it5),
        .state_valid(sv5), .busy(busy5), .done(done5), .steady(steady5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run4(input int rsel, input logic [1:0] md, input logic [3:0] init,
                        input logic [9:0] mx, input logic [3:0] msk, input logic [3:0] tv,
                        input logic [9:0] ti);
        rule_sel = rsel;
        mode4 = md; init4 = init; max4 = mx; mask4 = msk; tval4 = tv; titer4 = ti;
        seed4 = 16'h1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    logic [4:0]  exp5 [18];
    logic [17:0] vld5;
    logic [3:0]  exp4 [4];

    task automatic run_rand(input logic [15:0] sd, input string tag);
        mode5 = 2'd2; init5 = 5'b0; max5 = 10'd3; mask5 = '0; tval5 = '0;
        titer5 = 10'd0; seed5 = sd;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick();
            chk($sformatf("%s_state_c%0d", tag, k + 1), 64'(st5), 64'(exp5[k]));
            chk($sformatf("%s_valid_c%0d", tag, k + 1), 64'(sv5), 64'(vld5[k]));
        end
        chk({tag, "_iter"}, 64'(it5), 64'd3);
        tick();
        chk({tag, "_done"}, 64'(done5), 64'd1);
        chk({tag, "_steady"}, 64'(steady5), 64'd0);
    endtask

    initial begin
        exp5 = '{5'b00010, 5'b00011, 5'b00010, 5'b00011, 5'b00010,
                 5'b00011, 5'b00010, 5'b00011, 5'b00010, 5'b10010,
                 5'b10110, 5'b10110, 5'b10110, 5'b11110, 5'b11110,
                 5'b11010, 5'b11000, 5'b11001};
        vld5 = 18'b0;
        vld5[4] = 1'b1; vld5[9] = 1'b1; vld5[17] = 1'b1;

        rst_n = 1'b0; rule_sel = 0;
        start4 = 0; mode4 = 0; init4 = 0; max4 = 0; mask4 = 0; tval4 = 0; titer4 = 0; seed4 = 0;
        start5 = 0; mode5 = 0; init5 = 0; max5 = 0; mask5 = 0; tval5 = 0; titer5 = 0; seed5 = 0;
        #12;
        chk("rst_state", 64'(st4), 64'd0);
        chk("rst_iter", 64'(it4), 64'd0);
        chk("rst_flags", 64'({sv4, busy4, done4, steady4}), 64'd0);
        rst_n = 1'b1;
        tick();

        // sync rotate-left, limit 3
        run4(0, 2'd0, 4'b0001, 10'd3, 4'b0, 4'b0, 10'd0);
        exp4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("sync_rot_state%0d", k), 64'(st4), 64'(exp4[k]));
            chk($sformatf("sync_rot_valid%0d", k), 64'(sv4), 64'd1);
        end
        tick();
        chk("sync_rot_end", 64'({busy4, done4, steady4, sv4}), 64'b0100);
        chk("sync_rot_iter", 64'(it4), 64'd3);

        // sync identity: fixed point on first iteration
        run4(1, 2'd0, 4'b1010, 10'd10, 4'b0, 4'b0, 10'd0);
        tick();
        chk("id_state", 64'(st4), 64'b1010);
        chk("id_valid", 64'(sv4), 64'd1);
        chk("id_not_done_yet", 64'(done4), 64'd0);
        tick();
        chk("id_done_steady", 64'({done4, steady4}), 64'b11);
        chk("id_iter", 64'(it4), 64'd1);

        // toggle window on node 0, mode 3 behaves as sync
        run4(1, 2'd3, 4'b0000, 10'd10, 4'b0001, 4'b0001, 10'd2);
        exp4 = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("tog_state%0d", k), 64'(st4), 64'(exp4[k]));
            chk($sformatf("tog_done%0d", k), 64'(done4), 64'd0);
        end
        tick();
        chk("tog_done_steady", 64'({done4, steady4}), 64'b11);
        chk("tog_iter", 64'(it4), 64'd4);

        // round-robin invert, one iteration
        run4(2, 2'd1, 4'b0000, 10'd1, 4'b0, 4'b0, 10'd0);
        exp4 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_state%0d", k), 64'(st4), 64'(exp4[k]));
            chk($sformatf("rr_valid%0d", k), 64'(sv4), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("rr_iter", 64'(it4), 64'd1);
        tick();
        chk("rr_done_steady", 64'({done4, steady4}), 64'b10);

        // max_iter 0: straight to DONE, no update
        run4(2, 2'd0, 4'b0110, 10'd0, 4'b0, 4'b0, 10'd0);
        tick();
        chk("max0_state", 64'(st4), 64'b0110);
        chk("max0_flags", 64'({sv4, busy4, done4, steady4}), 64'b0010);
        chk("max0_iter", 64'(it4), 64'd0);

        // random order, seed 1 and seed 0 must match
        run_rand(16'h0001, "rand_s1");
        run_rand(16'h0000, "rand_s0");

        // start ignored in RUN, then async reset mid-run
        run4(0, 2'd0, 4'b0001, 10'd10, 4'b0, 4'b0, 10'd0);
        tick();
        chk("hs_state1", 64'(st4), 64'b0010);
        init4 = 4'b1111;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("hs_start_ignored", 64'(st4), 64'b0100);
        chk("hs_iter2", 64'(it4), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("hs_rst_busy", 64'(busy4), 64'd0);
        chk("hs_rst_state", 64'(st4), 64'd0);
        chk("hs_rst_iter", 64'(it4), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run4(0, 2'd0, 4'b0001, 10'd2, 4'b0, 4'b0, 10'd0);
        tick();
        chk("hs_rerun1", 64'(st4), 64'b0010);
        tick();
        chk("hs_rerun2", 64'(st4), 64'b0100);
        tick();
        chk("hs_rerun_done", 64'({done4, steady4, it4}), {2'b10, 10'd2});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
